// File: rtl/gf2_pkg.sv
// Shared definitions for the GF(2) solver family.
// Holds the solver state encoding and the width helpers used for port and
// counter sizing. The RREF engine uses the same package.
package gf2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    EVAL,
    ENUM,
    DONE
  } solver_state_e;

  // Bits needed to hold the values 0..n (minimum 1).
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Bits needed to index 0..n-1 (minimum 1).
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gf2_bit_deposit.sv
// Combinational parallel bit deposit (pdep).
// Bit k of src goes to the position of the k-th set bit of mask, counting
// from the LSB of mask. Positions of dst outside mask are 0.
//   src  in  SRC_W  packed source bits
//   mask in  WIDTH  destination positions
//   dst  out WIDTH  deposited result
module gf2_bit_deposit #(
  parameter int WIDTH = 8,
  parameter int SRC_W = 8
) (
  input  logic [SRC_W-1:0] src,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] dst
);

  always_comb begin
    int k;
    dst = '0;
    k   = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (mask[i]) begin
        // Mask bits beyond the source width receive 0.
        if (k < SRC_W) dst[i] = src[k];
        k++;
      end
    end
  end

endmodule

// File: rtl/gf2_min_weight_solver.sv
// Minimum-Hamming-weight solver for A*x = b over GF(2), fed with the RREF
// of [A|b]. Rows are MSB-aligned: variable j at bit MAX_COLS-1-j, RHS at
// bit MAX_COLS-cols. Scans rows for pivots, then enumerates every
// free-variable assignment, keeping the first strictly lightest x.
//   clk, rst       clock, synchronous active-high reset
//   rows, cols     matrix size (cols includes RHS), captured on start
//   start          solve request, accepted only in IDLE
//   RREF           row r = RREF[r], captured on start
//   busy           solve in progress
//   ready          one-cycle pulse when results become valid
//   inconsistent   no solution exists
//   too_many_free  free-variable count exceeds MAX_FREE
//   min_weight     weight of best x, all-ones when no result
//   solution       best x, MSB-aligned, RHS/unused bits 0
module gf2_min_weight_solver
  import gf2_pkg::*;
#(
  parameter int MAX_ROWS = 4,
  parameter int MAX_COLS = 8,
  parameter int MAX_FREE = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [cnt_w(MAX_ROWS)-1:0]         rows,
  input  logic [cnt_w(MAX_COLS)-1:0]         cols,
  input  logic                               start,
  input  logic [MAX_ROWS-1:0][MAX_COLS-1:0]  RREF,
  output logic                               busy,
  output logic                               ready,
  output logic                               inconsistent,
  output logic                               too_many_free,
  output logic [cnt_w(MAX_COLS)-1:0]         min_weight,
  output logic [MAX_COLS-1:0]                solution
);

  localparam int MAX_ROWS_W     = cnt_w(MAX_ROWS);
  localparam int MAX_COLS_W     = cnt_w(MAX_COLS);
  localparam int MAX_ROWS_IDX_W = idx_w(MAX_ROWS);
  localparam int MAX_COLS_IDX_W = idx_w(MAX_COLS);
  localparam int WGT_W          = MAX_COLS_W;
  localparam int CNT_W          = MAX_FREE + 1;

  function automatic logic [WGT_W-1:0] popcount(input logic [MAX_COLS-1:0] v);
    logic [WGT_W-1:0] c;
    c = '0;
    for (int i = 0; i < MAX_COLS; i++) c = c + WGT_W'(v[i]);
    return c;
  endfunction

  // Index of the highest set bit; 0 when v is zero (caller checks |v).
  function automatic logic [MAX_COLS_IDX_W-1:0] hsb(input logic [MAX_COLS-1:0] v);
    logic [MAX_COLS_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_COLS; i++) if (v[i]) idx = MAX_COLS_IDX_W'(i);
    return idx;
  endfunction

  function automatic logic [MAX_COLS-1:0] var_mask(input logic [MAX_COLS_W-1:0] c);
    logic [MAX_COLS-1:0] m;
    for (int j = 0; j < MAX_COLS; j++) m[j] = (j + int'(c)) > MAX_COLS;
    return m;
  endfunction

  function automatic logic [MAX_COLS-1:0] rhs_mask(input logic [MAX_COLS_W-1:0] c);
    logic [MAX_COLS-1:0] m;
    for (int j = 0; j < MAX_COLS; j++) m[j] = (j + int'(c)) == MAX_COLS;
    return m;
  endfunction

  solver_state_e                     state_q;
  logic [MAX_ROWS_W-1:0]             rows_q;
  logic [MAX_COLS-1:0]               varmask_q, rhsmask_q;
  logic [MAX_ROWS-1:0][MAX_COLS-1:0] row_q;
  logic [MAX_ROWS_IDX_W-1:0]         row_ctr_q;
  logic [MAX_COLS-1:0]               pivmask_q;
  logic [MAX_ROWS-1:0]               piv_vld_q;
  logic [MAX_COLS_IDX_W-1:0]         piv_idx_q [MAX_ROWS];
  logic                              inc_q;
  logic [CNT_W-1:0]                  cnt_q, last_q;
  logic [WGT_W-1:0]                  best_w_q, best_w_d;
  logic [MAX_COLS-1:0]               best_x_q, best_x_d;

  // Row scan
  logic [MAX_COLS-1:0]       cur_row, scan_vec;
  logic [MAX_COLS_IDX_W-1:0] scan_idx;
  logic                      scan_has, scan_rhs, scan_last;

  assign cur_row   = row_q[row_ctr_q];
  assign scan_vec  = cur_row & varmask_q;
  assign scan_idx  = hsb(scan_vec);
  assign scan_has  = |scan_vec;
  assign scan_rhs  = |(cur_row & rhsmask_q);
  assign scan_last = (MAX_ROWS_W'(row_ctr_q) + MAX_ROWS_W'(1)) == rows_q;

  // Enumeration datapath
  logic [MAX_COLS-1:0] freemask, f, x;
  logic [WGT_W-1:0]    nfree, x_w;
  logic [MAX_ROWS-1:0][MAX_COLS-1:0] xpiv;

  assign freemask = varmask_q & ~pivmask_q;
  assign nfree    = popcount(freemask);

  gf2_bit_deposit #(
    .WIDTH (MAX_COLS),
    .SRC_W (MAX_FREE)
  ) u_deposit (
    .src  (cnt_q[MAX_FREE-1:0]),
    .mask (freemask),
    .dst  (f)
  );

  // Each pivot variable is fixed by its row: rhs xor the row's free terms.
  for (genvar r = 0; r < MAX_ROWS; r++) begin : g_row
    logic bit_r;
    assign bit_r   = (|(row_q[r] & rhsmask_q)) ^ (^(row_q[r] & f));
    assign xpiv[r] = (piv_vld_q[r] && bit_r) ? (MAX_COLS'(1) << piv_idx_q[r]) : '0;
  end

  always_comb begin
    x = f;
    for (int r = 0; r < MAX_ROWS; r++) x = x | xpiv[r];
  end

  assign x_w = popcount(x);

  // Strict compare: on ties the earlier (lower cnt) assignment stays.
  always_comb begin
    best_w_d = best_w_q;
    best_x_d = best_x_q;
    if (x_w < best_w_q) begin
      best_w_d = x_w;
      best_x_d = x;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      busy          <= 1'b0;
      ready         <= 1'b0;
      inconsistent  <= 1'b0;
      too_many_free <= 1'b0;
      min_weight    <= '1;
      solution      <= '0;
      rows_q        <= '0;
      varmask_q     <= '0;
      rhsmask_q     <= '0;
      row_ctr_q     <= '0;
      pivmask_q     <= '0;
      piv_vld_q     <= '0;
      inc_q         <= 1'b0;
      cnt_q         <= '0;
      last_q        <= '0;
      best_w_q      <= '1;
      best_x_q      <= '0;
    end else begin
      ready <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            rows_q        <= rows;
            varmask_q     <= var_mask(cols);
            rhsmask_q     <= rhs_mask(cols);
            row_q         <= RREF;
            row_ctr_q     <= '0;
            pivmask_q     <= '0;
            piv_vld_q     <= '0;
            inc_q         <= 1'b0;
            inconsistent  <= 1'b0;
            too_many_free <= 1'b0;
            busy          <= 1'b1;
            state_q       <= SCAN;
          end
        end
        SCAN: begin
          if (scan_has) begin
            piv_vld_q[row_ctr_q] <= 1'b1;
            piv_idx_q[row_ctr_q] <= scan_idx;
            pivmask_q[scan_idx]  <= 1'b1;
          end else if (scan_rhs) begin
            inc_q <= 1'b1;
          end
          if (scan_last) state_q <= EVAL;
          else           row_ctr_q <= row_ctr_q + 1'b1;
        end
        EVAL: begin
          if (inc_q || (int'(nfree) > MAX_FREE)) begin
            inconsistent  <= inc_q;
            too_many_free <= ~inc_q;
            min_weight    <= '1;
            solution      <= '0;
            busy          <= 1'b0;
            ready         <= 1'b1;
            state_q       <= DONE;
          end else begin
            cnt_q    <= '0;
            last_q   <= (CNT_W'(1) << nfree) - CNT_W'(1);
            best_w_q <= '1;
            best_x_q <= '0;
            state_q  <= ENUM;
          end
        end
        ENUM: begin
          best_w_q <= best_w_d;
          best_x_q <= best_x_d;
          if (cnt_q == last_q) begin
            min_weight <= best_w_d;
            solution   <= best_x_d;
            busy       <= 1'b0;
            ready      <= 1'b1;
            state_q    <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf2_min_weight_solver.sv
// Bench for gf2_min_weight_solver: two instances (MAX_FREE=8 and MAX_FREE=2)
// share inputs; a reference model queues expected results and per-instance
// monitors check them whenever ready pulses.
module tb_gf2_min_weight_solver;

  localparam int MR  = 4;
  localparam int MC  = 8;
  localparam int MF  = 8;
  localparam int MF2 = 2;

  typedef struct {
    logic       inc;
    logic       tmf;
    logic [3:0] w;
    logic [7:0] sol;
    int         lat;
    int         t0;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [2:0]         rows;
  logic [3:0]         cols;
  logic               start;
  logic [MR-1:0][MC-1:0] rref;

  logic       busy_a, ready_a, inc_a, tmf_a;
  logic [3:0] w_a;
  logic [7:0] sol_a;
  logic       busy_b, ready_b, inc_b, tmf_b;
  logic [3:0] w_b;
  logic [7:0] sol_b;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea_m, eb_m;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gf2_min_weight_solver #(.MAX_ROWS(MR), .MAX_COLS(MC), .MAX_FREE(MF)) dut_a (
    .clk(clk), .rst(rst), .rows(rows), .cols(cols), .start(start), .RREF(rref),
    .busy(busy_a), .ready(ready_a), .inconsistent(inc_a), .too_many_free(tmf_a),
    .min_weight(w_a), .solution(sol_a)
  );

  gf2_min_weight_solver #(.MAX_ROWS(MR), .MAX_COLS(MC), .MAX_FREE(MF2)) dut_b (
    .clk(clk), .rst(rst), .rows(rows), .cols(cols), .start(start), .RREF(rref),
    .busy(busy_b), .ready(ready_b), .inconsistent(inc_b), .too_many_free(tmf_b),
    .min_weight(w_b), .solution(sol_b)
  );

  task automatic cmp(input string nm, input longint got, input longint expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, expv);
    end
  endtask

  // Reference: work per variable index, enumerate free assignments in order,
  // keep the first assignment of strictly lowest weight.
  function automatic exp_t model(input int nr, input int nc,
                                 input logic [MR-1:0][MC-1:0] m, input int maxf);
    exp_t e;
    int   nv, nfree, best, wgt, p;
    int   a[MR][MC];
    int   b[MR];
    int   piv[MR];
    bit   isp[MC];
    int   xv[MC];
    int   freel[$];
    bit   inc;
    nv = nc - 1;
    inc = 0;
    for (int j = 0; j < MC; j++) isp[j] = 0;
    for (int r = 0; r < nr; r++) begin
      b[r] = int'(m[r][MC-nc]);
      piv[r] = -1;
      for (int j = 0; j < nv; j++) begin
        a[r][j] = int'(m[r][MC-1-j]);
        if (a[r][j] == 1 && piv[r] < 0) piv[r] = j;
      end
      if (piv[r] >= 0) isp[piv[r]] = 1;
      else if (b[r] == 1) inc = 1;
    end
    // First free column gets cnt bit 0: that is the highest variable index.
    for (int j = nv - 1; j >= 0; j--) if (!isp[j]) freel.push_back(j);
    nfree = freel.size();
    e.t0 = 0;
    e.inc = inc;
    e.tmf = 0;
    e.w   = 4'hF;
    e.sol = 8'h00;
    e.lat = nr + 2;
    if (!inc && nfree > maxf) begin
      e.tmf = 1;
    end else if (!inc) begin
      best = 99;
      for (int c = 0; c < (1 << nfree); c++) begin
        for (int j = 0; j < MC; j++) xv[j] = 0;
        for (int k = 0; k < nfree; k++) xv[freel[k]] = (c >> k) & 1;
        for (int r = 0; r < nr; r++) begin
          if (piv[r] >= 0) begin
            p = b[r];
            for (int k = 0; k < nfree; k++) p = p ^ (a[r][freel[k]] & xv[freel[k]]);
            xv[piv[r]] = p;
          end
        end
        wgt = 0;
        for (int j = 0; j < nv; j++) wgt += xv[j];
        if (wgt < best) begin
          best = wgt;
          e.sol = 8'h00;
          for (int j = 0; j < nv; j++) e.sol[MC-1-j] = xv[j][0];
        end
      end
      e.w = 4'(best);
      e.lat = nr + 2 + (1 << nfree);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (ready_a) begin
      if (qa.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL A.unexpected_ready: got ready=1, expected no result pending");
      end else begin
        ea_m = qa.pop_front();
        cmp("A.inconsistent", inc_a, ea_m.inc);
        cmp("A.too_many_free", tmf_a, ea_m.tmf);
        cmp("A.min_weight", w_a, ea_m.w);
        cmp("A.solution", sol_a, ea_m.sol);
        cmp("A.latency", cyc - ea_m.t0, ea_m.lat);
        cmp("A.busy_at_ready", busy_a, 0);
      end
    end
    if (ready_b) begin
      if (qb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL B.unexpected_ready: got ready=1, expected no result pending");
      end else begin
        eb_m = qb.pop_front();
        cmp("B.inconsistent", inc_b, eb_m.inc);
        cmp("B.too_many_free", tmf_b, eb_m.tmf);
        cmp("B.min_weight", w_b, eb_m.w);
        cmp("B.solution", sol_b, eb_m.sol);
        cmp("B.latency", cyc - eb_m.t0, eb_m.lat);
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    cmp({tag, ".busy_a"}, busy_a, 0);   cmp({tag, ".ready_a"}, ready_a, 0);
    cmp({tag, ".inc_a"}, inc_a, 0);     cmp({tag, ".tmf_a"}, tmf_a, 0);
    cmp({tag, ".w_a"}, w_a, 4'hF);      cmp({tag, ".sol_a"}, sol_a, 0);
    cmp({tag, ".busy_b"}, busy_b, 0);   cmp({tag, ".w_b"}, w_b, 4'hF);
  endtask

  task automatic issue(input int nr, input int nc, input logic [MR-1:0][MC-1:0] m);
    exp_t ea, eb;
    ea = model(nr, nc, m, MF);
    eb = model(nr, nc, m, MF2);
    @(posedge clk); #1;
    rows = 3'(nr); cols = 4'(nc); rref = m; start = 1'b1;
    ea.t0 = cyc; eb.t0 = cyc;
    qa.push_back(ea); qb.push_back(eb);
    @(posedge clk); #1;
    start = 1'b0;
    // Inputs are captured; scramble them to show they are no longer read.
    for (int r = 0; r < MR; r++) rref[r] = 8'($urandom);
    rows = 3'($urandom_range(1, MR)); cols = 4'($urandom_range(2, MC));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 2000) begin
      @(posedge clk); n++;
    end
    if (qa.size() != 0 || qb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: got %0d/%0d results pending, expected 0", qa.size(), qb.size());
      qa.delete(); qb.delete();
    end
    @(posedge clk);
  endtask

  task automatic run(input int nr, input int nc, input logic [MR-1:0][MC-1:0] m,
                     input bit pulse_scan);
    issue(nr, nc, m);
    if (pulse_scan) begin
      // Device is in SCAN now; this start must be dropped.
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_idle();
  endtask

  task automatic gen(output int nr, output int nc, output logic [MR-1:0][MC-1:0] m);
    int rank;
    int pc[MR];
    bit isp[MC];
    nr = $urandom_range(1, MR);
    nc = $urandom_range(2, MC);
    for (int j = 0; j < MC; j++) isp[j] = 0;
    for (int r = 0; r < MR; r++) begin
      m[r] = 8'($urandom);
      if (r < nr) for (int bp = MC - nc; bp < MC; bp++) m[r][bp] = 1'b0;
    end
    rank = 0;
    for (int j = 0; j < nc - 1; j++) begin
      if (rank < nr && $urandom_range(0, 1) == 1) begin
        pc[rank] = j; isp[j] = 1; rank++;
      end
    end
    for (int i = 0; i < rank; i++) begin
      m[i][MC-1-pc[i]] = 1'b1;
      for (int j = pc[i] + 1; j < nc - 1; j++)
        if (!isp[j]) m[i][MC-1-j] = 1'($urandom_range(0, 1));
      m[i][MC-nc] = 1'($urandom_range(0, 1));
    end
    for (int i = rank; i < nr; i++) m[i][MC-nc] = ($urandom_range(0, 3) == 0);
  endtask

  logic [MR-1:0][MC-1:0] m1, m2, m3, m4, mr;
  int nr_r, nc_r;

  initial begin
    rst = 1'b1; start = 1'b0; rows = 3'd1; cols = 4'd2; rref = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    m1 = '0; m1[0] = 8'b1011_0000; m1[1] = 8'b0110_0000;
    m2 = '0; m2[0] = 8'b1001_0000; m2[1] = 8'b0101_0000; m2[2] = 8'b0010_0000;
    m3 = '0; m3[0] = 8'b1000_0000; m3[1] = 8'b0001_0000;
    m4 = '0;

    run(2, 4, m1, 1'b0);
    cmp("t1.min_weight", w_a, 1);
    cmp("t1.solution", sol_a, 8'b1000_0000);
    run(3, 4, m2, 1'b0);
    cmp("t2.min_weight", w_a, 2);
    cmp("t2.solution", sol_a, 8'b1100_0000);
    run(2, 4, m3, 1'b1);
    cmp("t3.inconsistent", inc_a, 1);
    cmp("t3.min_weight", w_a, 4'hF);
    run(1, 4, m4, 1'b0);
    cmp("t4.min_weight", w_a, 0);
    cmp("t4.solution", sol_a, 0);
    cmp("t5.too_many_free", tmf_b, 1);
    cmp("t5.min_weight", w_b, 4'hF);

    // Reset in the middle of enumeration.
    issue(1, 4, m4);
    repeat (5) @(posedge clk);
    #1;
    cmp("t6.busy_mid_enum", busy_a, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_vals("t6.reset");
    qa.delete(); qb.delete();
    #1 rst = 1'b0;
    run(2, 4, m1, 1'b1);
    cmp("t6.rerun_min_weight", w_a, 1);
    cmp("t6.rerun_solution", sol_a, 8'b1000_0000);

    for (int t = 0; t < 150; t++) begin
      gen(nr_r, nc_r, mr);
      run(nr_r, nc_r, mr, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
